// File: rtl/rr_one_finder_pkg.sv
// Shared types and helpers for the trailing-one / round-robin finder.
// onehot_of returns a wide vector; callers size-cast it to their own width.
package one_find_pkg;

  typedef enum logic {PRIO_FIXED, PRIO_RR} prio_mode_e;

  localparam int ONE_FIND_MAX_LEN = 1024;

  function automatic logic [ONE_FIND_MAX_LEN-1:0] onehot_of(input int unsigned idx);
    return ONE_FIND_MAX_LEN'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_one_finder_if.sv
// Request and result handshakes of rr_one_finder.
// master = requester/consumer side, slave = the finder.
interface rr_one_finder_if #(
  parameter int VEC_LEN = 8,
  parameter int IDX_W   = $clog2(VEC_LEN)
) ();
  logic [VEC_LEN-1:0] i_req_vec;
  logic               i_req_valid;
  logic               o_req_ready;
  logic               i_ptr_clr;
  logic               o_valid;
  logic               i_ready;
  logic [IDX_W-1:0]   o_idx;
  logic [VEC_LEN-1:0] o_onehot;
  logic               o_all_zero;

  modport master (
    output i_req_vec, i_req_valid, i_ptr_clr, i_ready,
    input  o_req_ready, o_valid, o_idx, o_onehot, o_all_zero
  );

  modport slave (
    input  i_req_vec, i_req_valid, i_ptr_clr, i_ready,
    output o_req_ready, o_valid, o_idx, o_onehot, o_all_zero
  );
endinterface

// File: rtl/rr_one_finder_trailing_one_find.sv
// Combinational trailing-one finder: log-depth 2:1 tree over the zero-padded vector.
// idx_o is meaningful only when all_zero_o is low.
module trailing_one_find #(
  parameter int VEC_LEN = 8,
  parameter int IDX_W   = $clog2(VEC_LEN)
) (
  input  logic [VEC_LEN-1:0] vec_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               all_zero_o
);
  localparam int LOGP = $clog2(VEC_LEN);
  localparam int P    = 1 << LOGP;

  logic [P-1:0]    v;
  logic [LOGP-1:0] ix [P];

  // Reduce in place: node n of a level is built from nodes 2n/2n+1 of the level below.
  always_comb begin
    v = P'(vec_i);
    for (int i = 0; i < P; i++) ix[i] = '0;
    for (int l = 0; l < LOGP; l++) begin
      for (int n = 0; n < (P >> (l + 1)); n++) begin
        ix[n] = v[2*n] ? ix[2*n] : (ix[2*n+1] | (LOGP'(1) << l));
        v[n]  = v[2*n] | v[2*n+1];
      end
    end
  end

  assign idx_o      = ix[0];
  assign all_zero_o = ~v[0];
endmodule

// File: rtl/rr_one_finder.sv
// Registered trailing-one finder with optional round-robin start pointer; result one cycle after accept.
// Request side stalls only while a result is held and the consumer is not ready.
module rr_one_finder
  import one_find_pkg::*;
#(
  parameter int         VEC_LEN = 8,
  parameter prio_mode_e MODE    = PRIO_RR,
  parameter int         IDX_W   = $clog2(VEC_LEN)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  rr_one_finder_if.slave bus
);
  logic               accept;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VEC_LEN-1:0] onehot_q, onehot_d;
  logic               all_zero_q, all_zero_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   all_idx, msk_idx, sel_idx;
  logic               all_zero, msk_zero;

  assign bus.o_req_ready = ~valid_q | bus.i_ready;
  assign accept          = bus.i_req_valid & bus.o_req_ready;

  trailing_one_find #(.VEC_LEN(VEC_LEN)) u_find_all (
    .vec_i      (bus.i_req_vec),
    .idx_o      (all_idx),
    .all_zero_o (all_zero)
  );

  generate
    if (MODE == PRIO_RR) begin : g_rr
      logic [VEC_LEN-1:0] masked;
      assign masked = bus.i_req_vec & ({VEC_LEN{1'b1}} << ptr_q);
      trailing_one_find #(.VEC_LEN(VEC_LEN)) u_find_msk (
        .vec_i      (masked),
        .idx_o      (msk_idx),
        .all_zero_o (msk_zero)
      );
    end else begin : g_fixed
      assign msk_idx  = '0;
      assign msk_zero = 1'b1;
    end
  endgenerate

  // Fall back to the unmasked search when nothing is set at or above ptr.
  always_comb begin
    sel_idx = msk_zero ? all_idx : msk_idx;
    if (all_zero) sel_idx = '0;
  end

  always_comb begin
    valid_d    = valid_q;
    idx_d      = idx_q;
    onehot_d   = onehot_q;
    all_zero_d = all_zero_q;
    ptr_d      = ptr_q;
    if (accept) begin
      valid_d    = 1'b1;
      idx_d      = sel_idx;
      onehot_d   = all_zero ? '0 : VEC_LEN'(onehot_of(32'(sel_idx)));
      all_zero_d = all_zero;
    end else if (bus.i_ready) begin
      valid_d = 1'b0;
    end
    if (bus.i_ptr_clr) begin
      ptr_d = '0;
    end else if (MODE == PRIO_RR && accept && !all_zero) begin
      ptr_d = (sel_idx == IDX_W'(VEC_LEN - 1)) ? '0 : sel_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q    <= 1'b0;
      idx_q      <= '0;
      onehot_q   <= '0;
      all_zero_q <= 1'b1;
      ptr_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      onehot_q   <= onehot_d;
      all_zero_q <= all_zero_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_idx      = idx_q;
  assign bus.o_onehot   = onehot_q;
  assign bus.o_all_zero = all_zero_q;
endmodule

// File: tb/tb_rr_one_finder.sv
// Directed vectors for 8-bit RR, 8-bit fixed and 5-bit RR finders, plus async reset mid-stream.
module tb_rr_one_finder;
  import one_find_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_one_finder_if #(.VEC_LEN(8)) bus8 ();
  rr_one_finder_if #(.VEC_LEN(8)) busf ();
  rr_one_finder_if #(.VEC_LEN(5)) bus5 ();

  rr_one_finder #(.VEC_LEN(8), .MODE(PRIO_RR))    u_rr8 (.i_clk(clk), .i_rst(rst), .bus(bus8));
  rr_one_finder #(.VEC_LEN(8), .MODE(PRIO_FIXED)) u_fx8 (.i_clk(clk), .i_rst(rst), .bus(busf));
  rr_one_finder #(.VEC_LEN(5), .MODE(PRIO_RR))    u_rr5 (.i_clk(clk), .i_rst(rst), .bus(bus5));

  typedef struct {
    int         dut;
    logic [7:0] vec;
    logic       vld;
    logic       rdy;
    logic       clr;
    int         e_rrdy;
    int         e_vld;
    int         e_idx;
    int         e_oh;
    int         e_zero;
    int         e_ptr;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(int d, logic [7:0] vec, logic vld, logic rdy, logic clr,
                              int e_rrdy, int e_vld, int e_idx, int e_oh, int e_zero, int e_ptr);
    vec_t r;
    r.dut = d; r.vec = vec; r.vld = vld; r.rdy = rdy; r.clr = clr;
    r.e_rrdy = e_rrdy; r.e_vld = e_vld; r.e_idx = e_idx;
    r.e_oh = e_oh; r.e_zero = e_zero; r.e_ptr = e_ptr;
    return r;
  endfunction

  task automatic check(input string name, input int step, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, required %0d", name, step, act, exp);
    end
  endtask

  task automatic idle_all();
    bus8.i_req_vec = '0; bus8.i_req_valid = 1'b0; bus8.i_ready = 1'b1; bus8.i_ptr_clr = 1'b0;
    busf.i_req_vec = '0; busf.i_req_valid = 1'b0; busf.i_ready = 1'b1; busf.i_ptr_clr = 1'b0;
    bus5.i_req_vec = '0; bus5.i_req_valid = 1'b0; bus5.i_ready = 1'b1; bus5.i_ptr_clr = 1'b0;
  endtask

  task automatic drive(input int d, input logic [7:0] vec, input logic vld,
                       input logic rdy, input logic clr);
    idle_all();
    case (d)
      0: begin bus8.i_req_vec = vec; bus8.i_req_valid = vld; bus8.i_ready = rdy; bus8.i_ptr_clr = clr; end
      1: begin busf.i_req_vec = vec; busf.i_req_valid = vld; busf.i_ready = rdy; busf.i_ptr_clr = clr; end
      default: begin
        bus5.i_req_vec = vec[4:0]; bus5.i_req_valid = vld; bus5.i_ready = rdy; bus5.i_ptr_clr = clr;
      end
    endcase
  endtask

  task automatic sample(input int d, output int rrdy, output int vld, output int idx,
                        output int oh, output int zero, output int ptr);
    case (d)
      0: begin
        rrdy = int'(bus8.o_req_ready); vld = int'(bus8.o_valid); idx = int'(bus8.o_idx);
        oh = int'(bus8.o_onehot); zero = int'(bus8.o_all_zero); ptr = int'(u_rr8.ptr_q);
      end
      1: begin
        rrdy = int'(busf.o_req_ready); vld = int'(busf.o_valid); idx = int'(busf.o_idx);
        oh = int'(busf.o_onehot); zero = int'(busf.o_all_zero); ptr = int'(u_fx8.ptr_q);
      end
      default: begin
        rrdy = int'(bus5.o_req_ready); vld = int'(bus5.o_valid); idx = int'(bus5.o_idx);
        oh = int'(bus5.o_onehot); zero = int'(bus5.o_all_zero); ptr = int'(u_rr5.ptr_q);
      end
    endcase
  endtask

  initial begin
    int rrdy, vld, idx, oh, zero, ptr;

    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      sample(d, rrdy, vld, idx, oh, zero, ptr);
      check("rst_valid", d, vld, 0);
      check("rst_idx", d, idx, 0);
      check("rst_onehot", d, oh, 0);
      check("rst_all_zero", d, zero, 1);
      check("rst_ptr", d, ptr, 0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 8-bit round robin: wrap, all-zero, backpressure, no-bubble refill, ptr clear
    tbl.push_back(mk(0, 8'h94, 1, 1, 0, 1, 1, 2, 8'h04, 0, 3));
    tbl.push_back(mk(0, 8'h94, 1, 1, 0, 1, 1, 4, 8'h10, 0, 5));
    tbl.push_back(mk(0, 8'h94, 1, 1, 0, 1, 1, 7, 8'h80, 0, 0));
    tbl.push_back(mk(0, 8'h94, 1, 1, 0, 1, 1, 2, 8'h04, 0, 3));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 1, 0, 8'h00, 1, 3));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00, 1, 3));
    tbl.push_back(mk(0, 8'h10, 1, 0, 0, 1, 1, 4, 8'h10, 0, 5));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 8'h01, 1, 0, 0, 0, 1, 4, 8'h10, 0, 5));
    tbl.push_back(mk(0, 8'h01, 1, 1, 0, 1, 1, 0, 8'h01, 0, 1));
    tbl.push_back(mk(0, 8'h03, 1, 1, 1, 1, 1, 1, 8'h02, 0, 0));
    tbl.push_back(mk(0, 8'h03, 1, 1, 0, 1, 1, 0, 8'h01, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h01, 0, 1));
    tbl.push_back(mk(0, 8'h10, 1, 1, 0, 1, 1, 4, 8'h10, 0, 5));
    // 8-bit fixed priority: lowest index always, ptr pinned at 0
    tbl.push_back(mk(1, 8'h94, 1, 1, 0, 1, 1, 2, 8'h04, 0, 0));
    tbl.push_back(mk(1, 8'h94, 1, 1, 0, 1, 1, 2, 8'h04, 0, 0));
    tbl.push_back(mk(1, 8'h94, 1, 1, 0, 1, 1, 2, 8'h04, 0, 0));
    tbl.push_back(mk(1, 8'h80, 1, 1, 0, 1, 1, 7, 8'h80, 0, 0));
    tbl.push_back(mk(1, 8'h94, 1, 1, 0, 1, 1, 2, 8'h04, 0, 0));
    // 5-bit round robin: wrap at a non-power-of-two length, ptr clear with accept
    tbl.push_back(mk(2, 8'h08, 1, 1, 0, 1, 1, 3, 8'h08, 0, 4));
    tbl.push_back(mk(2, 8'h11, 1, 1, 0, 1, 1, 4, 8'h10, 0, 0));
    tbl.push_back(mk(2, 8'h11, 1, 1, 0, 1, 1, 0, 8'h01, 0, 1));
    tbl.push_back(mk(2, 8'h04, 1, 1, 1, 1, 1, 2, 8'h04, 0, 0));
    tbl.push_back(mk(2, 8'h06, 1, 1, 0, 1, 1, 1, 8'h02, 0, 2));

    foreach (tbl[s]) begin
      drive(tbl[s].dut, tbl[s].vec, tbl[s].vld, tbl[s].rdy, tbl[s].clr);
      #1;
      sample(tbl[s].dut, rrdy, vld, idx, oh, zero, ptr);
      check("req_ready", s, rrdy, tbl[s].e_rrdy);
      @(posedge clk);
      #1;
      sample(tbl[s].dut, rrdy, vld, idx, oh, zero, ptr);
      check("valid", s, vld, tbl[s].e_vld);
      check("idx", s, idx, tbl[s].e_idx);
      check("onehot", s, oh, tbl[s].e_oh);
      check("all_zero", s, zero, tbl[s].e_zero);
      check("ptr", s, ptr, tbl[s].e_ptr);
    end

    // Async reset while a result is held and ptr=5; no clock edge before the check.
    drive(0, 8'h10, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 8'h00, 1'b0, 1'b0, 1'b0);
    sample(0, rrdy, vld, idx, oh, zero, ptr);
    check("pre_rst_valid", 0, vld, 1);
    check("pre_rst_idx", 0, idx, 4);
    check("pre_rst_ptr", 0, ptr, 5);
    #2;
    rst = 1'b1;
    #1;
    sample(0, rrdy, vld, idx, oh, zero, ptr);
    check("arst_valid", 0, vld, 0);
    check("arst_idx", 0, idx, 0);
    check("arst_onehot", 0, oh, 0);
    check("arst_all_zero", 0, zero, 1);
    check("arst_ptr", 0, ptr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rr_one_finder.md
Name: rr_one_finder

Overview:
- Registered, parametrised trailing-one finder with optional round-robin priority.
- Accepts a request vector over a valid/ready handshake. Finds the first set bit at or above a rotating start pointer, wrapping around, or from bit 0 in fixed mode.
- Returns index, one-hot and all-zero flag one cycle later over a second valid/ready handshake.
- Used as the grant/select stage for schedulers and free-list allocators in the core.

Parameters:
- VEC_LEN, 8, request vector width; any value >= 2, not required to be a power of two.
- MODE, PRIO_RR, priority mode (prio_mode_e): PRIO_FIXED = lowest index wins; PRIO_RR = search starts at the rotating pointer.
- IDX_W, $clog2(VEC_LEN), index width; derived, not to be overridden.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_req_vec  input  VEC_LEN  request vector.
- i_req_valid  input  1  i_req_vec valid.
- o_req_ready  output  1  block can accept a request this cycle.
- i_ptr_clr  input  1  synchronous clear of the round-robin pointer to 0.
- o_valid  output  1  result registers hold a valid result.
- i_ready  input  1  consumer accepts the result.
- o_idx  output  IDX_W  index of the selected bit.
- o_onehot  output  VEC_LEN  one-hot of the selected bit; all zero if no bit set.
- o_all_zero  output  1  captured vector had no bit set.

Behaviour:
- Reset (async assert): o_valid=0, o_idx=0, o_onehot=0, o_all_zero=1, pointer ptr=0. Release is synchronised externally.
- o_req_ready = ~o_valid | i_ready (combinational). Accept = i_req_valid & o_req_ready.
- Latency: result is visible in o_* on the cycle after accept. Throughput is 1 per cycle when i_ready is held high.
- On accept: o_valid<=1; o_idx, o_onehot and o_all_zero are loaded from the search below.
- Result drain: i_ready & o_valid & ~accept gives o_valid<=0. The data registers hold their last value.
- Stability: while o_valid & ~i_ready, all o_* are held stable.
- Search, PRIO_RR:
  - masked = i_req_vec & (all-ones << ptr).
  - If masked != 0, select the trailing one of masked; else select the trailing one of i_req_vec.
- Search, PRIO_FIXED: select the trailing one of i_req_vec; ptr is held at 0.
- All-zero vector: o_all_zero=1, o_idx=0, o_onehot=0, o_valid still asserts (result is consumed like any other); ptr unchanged.
- Pointer update (PRIO_RR): on accept of a non-zero vector, ptr <= idx+1. If idx == VEC_LEN-1, ptr <= 0 (wrap for non-power-of-2 lengths too). ptr always stays in 0..VEC_LEN-1.
- i_ptr_clr: ptr <= 0 next cycle. It has priority over a same-cycle pointer update. The search in that same cycle still uses the old ptr.
- Simultaneous drain and accept: new result replaces the old one, o_valid stays 1, no bubble.
- i_req_vec bits above VEC_LEN do not exist. Results are defined for every input; no X propagation.
- o_idx width is IDX_W even when VEC_LEN is not a power of two. Values >= VEC_LEN never appear.

Decomposition:
- Package one_find_pkg holds:
  - typedef enum logic {PRIO_FIXED, PRIO_RR} prio_mode_e;
  - function onehot_of(idx) helper, parametrised through the module.
- Sub-module trailing_one_find (VEC_LEN): purely combinational; outputs idx and all_zero. It is a log-depth 2:1 tree over the zero-padded vector and must be correct for all inputs.
  - Instantiate it twice: once on masked, once on i_req_vec.
  - In PRIO_FIXED the masked instance is optimised away.
- The top holds the handshake, the output registers and the pointer.

Test Plan:
- VEC_LEN=8, RR, i_ready=1; from reset send 8'b1001_0100 three times:
  - results are idx 2, 4, 7; ptr ends 0 (wrap).
  - 4th send gives idx 2 again.
- VEC_LEN=8, FIXED; send 8'b1001_0100 repeatedly: idx=2, o_onehot=8'b0000_0100 every time; ptr stays 0.
- Backpressure: hold i_ready=0 after one accept (8'b0001_0000 -> idx 4):
  - o_req_ready=0 and o_* stable for 5 cycles.
  - Raise i_ready in the same cycle as a new valid 8'b0000_0001: o_idx=0 the next cycle, no bubble.
- All-zero input 8'h00 with ptr=3: o_valid=1, o_all_zero=1, o_idx=0, o_onehot=0; ptr remains 3.
- VEC_LEN=5, RR; send 5'b1_0001 with ptr=4:
  - idx=4, ptr wraps to 0; next idx=0, then ptr=1.
  - Assert i_ptr_clr together with an accept of 5'b0_0100: idx=2, ptr=0 afterwards.
- Assert i_rst mid-stream with o_valid=1, ptr=5: outputs and ptr return to reset values immediately (asynchronously), without waiting for a clock edge.
